// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths and depths and the byte type
// carried between RX_READ, TX_WRITE and the APB slaves.
package uart_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: store one entry per enabled edge.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer between the UART receiver and the APB read
// path. The receiver cannot stall, so a byte offered while full is dropped
// and recorded in a sticky overrun flag. irq is a registered level.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_RX_FIFO_DEPTH,
  parameter int IRQ_THRESH = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  pclk,
  input  logic                  prstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  flush,
  input  logic                  overrun_clr,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  overrun,
  output logic                  irq
);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          overrun_q, overrun_d;
  logic          irq_q,     irq_d;
  logic          push, pop, drop, wr_en;

  // Flags decode from the registered count only.
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = !empty;

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign pop      = out_valid & out_ready;
  assign in_ready = !full | pop;
  assign push     = in_valid & in_ready;
  // A byte discarded by flush is not an overrun.
  assign drop     = in_valid & !in_ready & !flush;
  assign wr_en    = push & !flush;

  // Next-state for pointers, occupancy, sticky overrun and irq level.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end
    // Set beats clear when a drop and overrun_clr coincide.
    overrun_d = drop | (overrun_q & !overrun_clr);
    irq_d     = (count_d >= (AW+1)'(IRQ_THRESH)) | overrun_d;
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  assign count   = count_q;
  assign overrun = overrun_q;
  assign irq     = irq_q;

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk_i   (pclk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, IRQ_THRESH=1).
module tb_uart_rx_fifo;

  logic       pclk = 1'b0;
  logic       prstn;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic       flush, overrun_clr;
  logic [4:0] count;
  logic       full, empty, overrun, irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .IRQ_THRESH(1)) dut (
    .pclk        (pclk),
    .prstn       (prstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .flush       (flush),
    .overrun_clr (overrun_clr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overrun     (overrun),
    .irq         (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"},   32'(count),     0);
    chk({tag, "_empty"},   32'(empty),     1);
    chk({tag, "_full"},    32'(full),      0);
    chk({tag, "_ovalid"},  32'(out_valid), 0);
    chk({tag, "_inready"}, 32'(in_ready),  1);
    chk({tag, "_overrun"}, 32'(overrun),   0);
    chk({tag, "_irq"},     32'(irq),       0);
  endtask

  task automatic push1(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] t1 [3];
    int i, npushed;
    logic pe, po;

    t1[0] = 8'h41; t1[1] = 8'h42; t1[2] = 8'h43;
    idle(); in_data = 8'h00; prstn = 1'b0;
    #12;
    chk_reset("rst");
    prstn = 1'b1;
    tick();

    // 1: three pushes, no pops
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = t1[k];
      #1 chk($sformatf("t1_inready%0d", k), 32'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    chk("t1_count", 32'(count), 3);
    chk("t1_data",  32'(out_data), 32'h41);
    chk("t1_irq",   32'(irq), 1);

    // 2: pop all in order, then a pop while empty
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t2_pop%0d", k), 32'(out_data), 32'(t1[k]));
      tick();
    end
    chk("t2_empty", 32'(empty), 1);
    chk("t2_irq",   32'(irq), 0);
    tick();
    chk("t2_xpop_count", 32'(count), 0);
    chk("t2_xpop_valid", 32'(out_valid), 0);
    out_ready = 1'b0;

    // 3: fill, drop one, drain, clear overrun
    for (int k = 0; k < 16; k++) push1(8'(k));
    chk("t3_full",    32'(full), 1);
    chk("t3_inready", 32'(in_ready), 0);
    chk("t3_count",   32'(count), 16);
    push1(8'hAA);
    chk("t3_overrun", 32'(overrun), 1);
    chk("t3_count2",  32'(count), 16);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t3_pop%0d", k), 32'(out_data), 32'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("t3_empty",      32'(empty), 1);
    chk("t3_ovr_sticky", 32'(overrun), 1);
    chk("t3_irq_ovr",    32'(irq), 1);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("t3_ovr_clr", 32'(overrun), 0);
    chk("t3_irq_clr", 32'(irq), 0);

    // 4: push and pop together while full
    for (int k = 0; k < 16; k++) push1(8'(k));
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    #1;
    chk("t4_inready", 32'(in_ready), 1);
    chk("t4_head",    32'(out_data), 32'h00);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_count",   32'(count), 16);
    chk("t4_overrun", 32'(overrun), 0);
    chk("t4_head2",   32'(out_data), 32'h01);
    // drop and clear in the same cycle: set wins
    in_valid = 1'b1; in_data = 8'h99; overrun_clr = 1'b1;
    tick();
    idle();
    chk("t4_setwins", 32'(overrun), 1);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t4_pop%0d", k), 32'(out_data), (k == 15) ? 32'h55 : 32'(k + 1));
      tick();
    end
    out_ready = 1'b0;
    chk("t4_empty", 32'(empty), 1);

    // 5: interleaved traffic across pointer wrap
    npushed = 0; i = 0;
    while (!(npushed == 20 && q.size() == 0) && i < 100) begin
      pe = (npushed < 20);
      po = (q.size() > 0) && (i % 3 != 0);
      in_valid = pe; in_data = 8'(8'h80 + npushed); out_ready = po;
      #1;
      chk($sformatf("t5_valid%0d", i), 32'(out_valid), 32'(q.size() > 0));
      if (po) chk($sformatf("t5_data%0d", i), 32'(out_data), 32'(q[0]));
      tick();
      if (po) void'(q.pop_front());
      if (pe) begin q.push_back(8'(8'h80 + npushed)); npushed++; end
      i++;
    end
    idle();
    chk("t5_bound", 32'(i < 100), 1);
    chk("t5_count", 32'(count), 0);

    // 6: flush with 5 entries and an incoming byte; overrun is still set
    for (int k = 0; k < 5; k++) push1(8'(8'h10 + k));
    chk("t6_count5", 32'(count), 5);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tick();
    idle();
    chk("t6_count",   32'(count), 0);
    chk("t6_empty",   32'(empty), 1);
    chk("t6_overrun", 32'(overrun), 1);
    push1(8'h78);
    chk("t6_no77",    32'(out_data), 32'h78);
    chk("t6_count1",  32'(count), 1);
    // async reset mid-traffic
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    #2 prstn = 1'b0;
    #1;
    chk_reset("t6_rst");
    idle();
    tick();
    prstn = 1'b1;
    tick();
    push1(8'h33);
    chk("t6_post_data",  32'(out_data), 32'h33);
    chk("t6_post_count", 32'(count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_rx_fifo
